// File: rtl/pic24_seq_pkg.sv
// Shared opcodes, field positions and FSM encoding
// for the PIC24 ICSP script sequencer.
package pic24_seq_pkg;

    localparam logic [3:0] OP_SIX    = 4'd0;
    localparam logic [3:0] OP_REGOUT = 4'd1;
    localparam logic [3:0] OP_LOOP   = 4'd2;
    localparam logic [3:0] OP_WAIT   = 4'd3;
    localparam logic [3:0] OP_HALT   = 4'd4;

    localparam int OPC_MSB   = 27;
    localparam int OPC_LSB   = 24;
    localparam int PAY_MSB   = 23;
    localparam int LOOPN_MSB = 23;
    localparam int LOOPN_LSB = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_RDWAIT,
        S_DELAY
    } seq_state_t;

endpackage

// File: rtl/pic24_rdata_fifo.sv
// Synchronous FIFO holding REGOUT read data for the host.
// Push is blocked when full, pop ignored when empty.
module pic24_rdata_fifo #(
    parameter int W         = 16,
    parameter int DEPTHlog2 = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int DEPTH = 1 << DEPTHlog2;

    logic [W-1:0]         r_mem [DEPTH];
    logic [DEPTHlog2-1:0] r_wp;
    logic [DEPTHlog2-1:0] r_rp;
    logic [DEPTHlog2:0]   r_cnt;
    logic                 w_push;
    logic                 w_pop;

    assign o_full  = (r_cnt == DEPTH[DEPTHlog2:0]);
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_rp];

    // storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_wdata;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/pic24_script_sequencer.sv
// Script-driven sequencer feeding the PIC24 ICSP engine
// from a host-loaded RAM, with loop/wait/halt opcodes.
module pic24_script_sequencer
    import pic24_seq_pkg::*;
#(
    parameter int MEMSIZElog2 = 7,
    parameter int FIFOlog2    = 4,
    parameter int DELAYW      = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [MEMSIZElog2-1:0] wr_addr,
    input  logic [31:0]            wr_data,
    input  logic                   start,
    input  logic [MEMSIZElog2-1:0] start_addr,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [23:0]            eng_instr,
    output logic                   eng_cmd,
    output logic                   eng_valid,
    input  logic                   eng_ready,
    input  logic                   eng_dvalid,
    input  logic [15:0]            eng_dout,
    output logic                   rd_valid,
    output logic [15:0]            rd_data,
    input  logic                   rd_ready,
    output logic                   rd_overflow
);

    localparam int M = MEMSIZElog2;

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [M-1:0]      r_pc;
    logic [M-1:0]      w_pc_nxt;
    logic [M-1:0]      w_pc_inc;
    logic [31:0]       r_mem [1 << M];
    logic [31:0]       r_rdata;
    logic [23:0]       r_instr;
    logic              r_cmd;
    logic [7:0]        r_loop_cnt;
    logic              r_loop_active;
    logic [DELAYW-1:0] r_dly;
    logic              r_done;
    logic              r_error;
    logic              r_ovf;

    logic [3:0]        w_op;
    logic [23:0]       w_pay;
    logic [7:0]        w_loop_n;
    logic [7:0]        w_loop_dec;
    logic [M-1:0]      w_target;
    logic [DELAYW-1:0] w_wait;
    logic              w_unused;
    logic              w_busy;
    logic              w_full;
    logic              w_empty;
    logic              w_eng_valid;
    logic              w_start_ok;
    logic              w_ld_issue;
    logic              w_loop_arm;
    logic              w_loop_step;
    logic              w_loop_disarm;
    logic              w_dly_load;
    logic              w_err_set;
    logic              w_done_set;
    logic              w_push;

    assign w_op       = r_rdata[OPC_MSB:OPC_LSB];
    assign w_pay      = r_rdata[PAY_MSB:0];
    assign w_loop_n   = r_rdata[LOOPN_MSB:LOOPN_LSB];
    assign w_target   = r_rdata[M-1:0];
    assign w_wait     = r_rdata[DELAYW-1:0];
    assign w_unused   = ^r_rdata[31:28];
    assign w_loop_dec = r_loop_cnt - 8'd1;
    assign w_pc_inc   = r_pc + 1'b1;
    assign w_busy     = (r_state != S_IDLE);

    assign busy        = w_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign eng_instr   = r_instr;
    assign eng_cmd     = r_cmd;
    assign eng_valid   = w_eng_valid;
    assign rd_valid    = ~w_empty;
    assign rd_overflow = r_ovf;

    // script RAM: host write port, synchronous read at pc
    always_ff @(posedge clk) begin
        if (wr_en && !w_busy) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rdata <= r_mem[r_pc];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state, pc and datapath control strobes
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_eng_valid   = 1'b0;
        w_start_ok    = 1'b0;
        w_ld_issue    = 1'b0;
        w_loop_arm    = 1'b0;
        w_loop_step   = 1'b0;
        w_loop_disarm = 1'b0;
        w_dly_load    = 1'b0;
        w_err_set     = 1'b0;
        w_done_set    = 1'b0;
        w_push        = 1'b0;
        if (r_state == S_ISSUE) begin
            w_eng_valid = ~r_cmd | ~w_full;
        end
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_start_ok  = 1'b1;
                        w_pc_nxt    = start_addr;
                        w_state_nxt = S_FETCH;
                    end
                end
                S_FETCH: begin
                    w_state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    case (w_op)
                        OP_SIX, OP_REGOUT: begin
                            w_ld_issue  = 1'b1;
                            w_state_nxt = S_ISSUE;
                        end
                        OP_LOOP: begin
                            w_state_nxt = S_FETCH;
                            w_pc_nxt    = w_pc_inc;
                            if (!r_loop_active) begin
                                if (w_loop_n != 8'd0) begin
                                    w_loop_arm = 1'b1;
                                    w_pc_nxt   = w_target;
                                end
                            end else if (w_loop_dec != 8'd0) begin
                                w_loop_step = 1'b1;
                                w_pc_nxt    = w_target;
                            end else begin
                                w_loop_disarm = 1'b1;
                            end
                        end
                        OP_WAIT: begin
                            if (w_wait == '0) begin
                                w_state_nxt = S_FETCH;
                                w_pc_nxt    = w_pc_inc;
                            end else begin
                                w_dly_load  = 1'b1;
                                w_state_nxt = S_DELAY;
                            end
                        end
                        OP_HALT: begin
                            w_done_set  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                        default: begin
                            w_err_set   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end
                S_ISSUE: begin
                    if (w_eng_valid && eng_ready) begin
                        if (r_cmd) begin
                            w_state_nxt = S_RDWAIT;
                        end else begin
                            w_state_nxt = S_FETCH;
                            w_pc_nxt    = w_pc_inc;
                        end
                    end
                end
                S_RDWAIT: begin
                    if (eng_dvalid) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_FETCH;
                        w_pc_nxt    = w_pc_inc;
                    end
                end
                S_DELAY: begin
                    if (r_dly == DELAYW'(1)) begin
                        w_state_nxt = S_FETCH;
                        w_pc_nxt    = w_pc_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // pc, engine request, loop/delay counters and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= '0;
            r_instr       <= '0;
            r_cmd         <= 1'b0;
            r_loop_cnt    <= '0;
            r_loop_active <= 1'b0;
            r_dly         <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_pc   <= w_pc_nxt;
            r_done <= w_done_set;
            if (w_ld_issue) begin
                r_instr <= w_pay;
                r_cmd   <= (w_op == OP_REGOUT);
            end
            if (w_start_ok || w_loop_disarm) begin
                r_loop_active <= 1'b0;
                r_loop_cnt    <= '0;
            end else if (w_loop_arm) begin
                r_loop_active <= 1'b1;
                r_loop_cnt    <= w_loop_n;
            end else if (w_loop_step) begin
                r_loop_cnt <= w_loop_dec;
            end
            if (w_dly_load) begin
                r_dly <= w_wait;
            end else if (r_state == S_DELAY) begin
                r_dly <= r_dly - 1'b1;
            end
            if (w_start_ok) begin
                r_error <= 1'b0;
            end else if (w_err_set) begin
                r_error <= 1'b1;
            end
            if (w_start_ok) begin
                r_ovf <= 1'b0;
            end else if (eng_dvalid && r_state != S_RDWAIT) begin
                r_ovf <= 1'b1;
            end
        end
    end

    pic24_rdata_fifo #(
        .W         (16),
        .DEPTHlog2 (FIFOlog2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (eng_dout),
        .i_pop   (rd_ready),
        .o_rdata (rd_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_pic24_script_sequencer.sv
// Scoreboard bench for pic24_script_sequencer with a
// small engine responder and a decoupled output monitor.
module tb_pic24_script_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic [6:0]  start_addr;
    logic        abort;
    logic        busy;
    logic        done;
    logic        error;
    logic [23:0] eng_instr;
    logic        eng_cmd;
    logic        eng_valid;
    logic        eng_ready;
    logic        eng_dvalid;
    logic [15:0] eng_dout;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_ready;
    logic        rd_overflow;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    int acc_rg = 0;

    logic [24:0] exp_x [$];
    logic [15:0] exp_rd [$];
    logic [15:0] rsp_q [$];

    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [24:0] prev_x = '0;

    always #5 clk = ~clk;

    pic24_script_sequencer #(
        .MEMSIZElog2 (7),
        .FIFOlog2    (1),
        .DELAYW      (24)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .start_addr  (start_addr),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .eng_instr   (eng_instr),
        .eng_cmd     (eng_cmd),
        .eng_valid   (eng_valid),
        .eng_ready   (eng_ready),
        .eng_dvalid  (eng_dvalid),
        .eng_dout    (eng_dout),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .rd_overflow (rd_overflow)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(logic [3:0] op, logic [23:0] p);
        return {4'h0, op, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [6:0] a, logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic go(logic [6:0] a);
        start      = 1'b1;
        start_addr = a;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(int d0, int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", done_cnt - d0, 1);
    endtask

    task automatic serve(int d);
        int n = 0;
        while (!eng_valid && n < 50) begin
            tick();
            n++;
        end
        chk("eng_valid_up", {31'd0, eng_valid}, 1);
        repeat (d) tick();
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
    endtask

    // monitor: engine transfers, stalls, host pops, done pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_v && !prev_r && !abort) begin
                chk("hold_valid", {31'd0, eng_valid}, 1);
                chk("hold_instr", {7'd0, eng_cmd, eng_instr}, {7'd0, prev_x});
            end
            if (eng_valid && eng_ready) begin
                xfer_cnt++;
                if (eng_cmd) acc_rg++;
                if (exp_x.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL eng_xfer: unexpected %h", {eng_cmd, eng_instr});
                end else begin
                    chk("eng_xfer", {7'd0, eng_cmd, eng_instr}, {7'd0, exp_x.pop_front()});
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_pop: unexpected %h", rd_data);
                end else begin
                    chk("rd_data", {16'd0, rd_data}, {16'd0, exp_rd.pop_front()});
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", {31'd0, busy}, 0);
            end
        end
        prev_v = eng_valid;
        prev_r = eng_ready;
        prev_x = {eng_cmd, eng_instr};
    end

    // engine read responder: data two cycles after a REGOUT
    initial begin
        int seen = 0;
        int dly = 0;
        eng_dvalid = 1'b0;
        eng_dout   = '0;
        forever begin
            @(posedge clk);
            #1;
            eng_dvalid = 1'b0;
            if (dly > 0) begin
                dly--;
                if (dly == 0 && rsp_q.size() > 0) begin
                    eng_dvalid = 1'b1;
                    eng_dout   = rsp_q.pop_front();
                end
            end
            if (acc_rg != seen) begin
                seen = acc_rg;
                dly  = 2;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int x0;
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        start      = 1'b0;
        start_addr = '0;
        abort      = 1'b0;
        eng_ready  = 1'b0;
        rd_ready   = 1'b0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_error", {31'd0, error}, 0);
        chk("rst_valid", {31'd0, eng_valid}, 0);
        chk("rst_rdvalid", {31'd0, rd_valid}, 0);
        chk("rst_ovf", {31'd0, rd_overflow}, 0);
        chk("rst_instr", {7'd0, eng_cmd, eng_instr}, 0);
        rst = 1'b0;
        tick();

        wr(7'h00, mk(4'd0, 24'h000000));
        wr(7'h01, mk(4'd0, 24'h040200));
        wr(7'h02, mk(4'd4, 24'h0));
        wr(7'h08, mk(4'd1, 24'hBA0880));
        wr(7'h09, mk(4'd1, 24'hBA0881));
        wr(7'h0A, mk(4'd4, 24'h0));
        wr(7'h10, 32'hAF000000);
        wr(7'h20, mk(4'd0, 24'h111111));
        wr(7'h21, mk(4'd2, 24'h030020));
        wr(7'h22, mk(4'd4, 24'h0));
        wr(7'h30, mk(4'd1, 24'hBA0001));
        wr(7'h31, mk(4'd1, 24'hBA0002));
        wr(7'h32, mk(4'd1, 24'hBA0003));
        wr(7'h33, mk(4'd4, 24'h0));
        wr(7'h40, mk(4'd3, 24'd1000));
        wr(7'h41, mk(4'd4, 24'h0));

        // two SIX then HALT, ready always high
        eng_ready = 1'b1;
        exp_x.push_back({1'b0, 24'h000000});
        exp_x.push_back({1'b0, 24'h040200});
        d0 = done_cnt;
        go(7'h00);
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_valid1", {31'd0, eng_valid}, 0);
        tick();
        chk("t1_valid2", {31'd0, eng_valid}, 0);
        tick();
        chk("t1_valid3", {31'd0, eng_valid}, 1);
        wait_done(d0, 50);
        chk("t1_xfers", xfer_cnt, 2);
        eng_ready = 1'b0;
        tick();

        // two REGOUTs with 5-cycle ready stalls
        rd_ready = 1'b1;
        exp_x.push_back({1'b1, 24'hBA0880});
        exp_x.push_back({1'b1, 24'hBA0881});
        rsp_q.push_back(16'h1234);
        rsp_q.push_back(16'hABCD);
        exp_rd.push_back(16'h1234);
        exp_rd.push_back(16'hABCD);
        d0 = done_cnt;
        go(7'h08);
        serve(5);
        serve(5);
        wait_done(d0, 50);
        tick();
        tick();
        chk("t2_rd_empty", {31'd0, rd_valid}, 0);
        rd_ready = 1'b0;

        // LOOP N=3 around one SIX
        eng_ready = 1'b1;
        repeat (4) exp_x.push_back({1'b0, 24'h111111});
        x0 = xfer_cnt;
        d0 = done_cnt;
        go(7'h20);
        wait_done(d0, 100);
        chk("t3_xfers", xfer_cnt - x0, 4);

        // depth-2 FIFO, host not popping
        exp_x.push_back({1'b1, 24'hBA0001});
        exp_x.push_back({1'b1, 24'hBA0002});
        exp_x.push_back({1'b1, 24'hBA0003});
        rsp_q.push_back(16'h0001);
        rsp_q.push_back(16'h0002);
        rsp_q.push_back(16'h0003);
        exp_rd.push_back(16'h0001);
        exp_rd.push_back(16'h0002);
        exp_rd.push_back(16'h0003);
        x0 = xfer_cnt;
        d0 = done_cnt;
        go(7'h30);
        repeat (40) tick();
        chk("t4_stall_xfers", xfer_cnt - x0, 2);
        chk("t4_stall_valid", {31'd0, eng_valid}, 0);
        chk("t4_stall_busy", {31'd0, busy}, 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        wait_done(d0, 50);
        chk("t4_xfers", xfer_cnt - x0, 3);
        rd_ready = 1'b1;
        repeat (4) tick();
        rd_ready = 1'b0;
        chk("t4_ovf", {31'd0, rd_overflow}, 0);
        chk("t4_rd_empty", {31'd0, rd_valid}, 0);

        // illegal opcode
        x0 = xfer_cnt;
        go(7'h10);
        tick();
        tick();
        chk("t5_error", {31'd0, error}, 1);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_xfers", xfer_cnt - x0, 0);

        // abort during WAIT 1000, write while busy dropped
        d0 = done_cnt;
        go(7'h40);
        chk("t6_err_clr", {31'd0, error}, 0);
        wr(7'h00, 32'h0F000000);
        repeat (10) tick();
        chk("t6_busy", {31'd0, busy}, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_busy", {31'd0, busy}, 0);
        chk("t6_abort_valid", {31'd0, eng_valid}, 0);
        repeat (5) tick();
        chk("t6_no_done", done_cnt - d0, 0);

        exp_x.push_back({1'b0, 24'h000000});
        exp_x.push_back({1'b0, 24'h040200});
        x0 = xfer_cnt;
        go(7'h00);
        wait_done(d0, 50);
        chk("t6_rerun_xfers", xfer_cnt - x0, 2);
        tick();

        chk("end_exp_x", exp_x.size(), 0);
        chk("end_exp_rd", exp_rd.size(), 0);
        chk("end_dones", done_cnt, 5);
        chk("end_xfers", xfer_cnt, 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
